// File: rtl/mopshub_test_sequencer.sv
`timescale 1ns/1ps
// MOPSHUB test sequencer: walks CAN buses 0..n_buses issuing RX/TX/advanced test requests and tallies pass/fail.
// Optional feature macro SEQ_TIMEOUT_EN builds the per-test timeout counter; without it RUN waits for the end pulse.
module mopshub_test_sequencer #(
  parameter int N_BUS      = 16,
  parameter int BUS_W      = 5,
  parameter int GAP_CYCLES = 120,
  parameter int TIMEOUT    = 4096,
  parameter int CNT_W      = 16
) (
  input  logic             clk_40_m,
  input  logic             rst,
  input  logic             start,
  input  logic             trim_en,
  input  logic [1:0]       mode,
  input  logic             loop_en,
  input  logic [BUS_W-1:0] n_buses,
  input  logic             sign_on,
  input  logic             end_power_init,
  input  logic             test_rx_end,
  input  logic             test_tx_end,
  input  logic             test_advanced_end,
  output logic             test_rx,
  output logic             test_tx,
  output logic             test_advanced,
  output logic [BUS_W-1:0] bus_sel,
  output logic             endwait_all,
  output logic             osc_auto_trim,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [BUS_W-1:0] err_bus
);

  // Handshake: a request level stays high for the whole RUN state; only the end pulse
  // matching the active request (sampled high on a rising edge) completes the test.
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SIGNON, S_ARM, S_RUN, S_ENDWAIT, S_GAP, S_NEXT, S_FINISH
  } state_t;

  localparam logic [1:0] MODE_TX   = 2'd1;
  localparam logic [1:0] MODE_RXTX = 2'd2;
  localparam logic [1:0] MODE_ADV  = 2'd3;
  localparam logic PH_RX = 1'b0;
  localparam logic PH_TX = 1'b1;
  localparam logic [BUS_W-1:0] MAX_BUS = BUS_W'(N_BUS - 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic             phase_q, phase_d;
  logic [BUS_W-1:0] last_bus_q, last_bus_d;
  logic [BUS_W-1:0] bus_sel_q, bus_sel_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [BUS_W-1:0] err_bus_q, err_bus_d;
  logic             test_rx_q, test_rx_d;
  logic             test_tx_q, test_tx_d;
  logic             test_adv_q, test_adv_d;
  logic             endwait_q, endwait_d;
  logic             trim_q, trim_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             end_hit;
  logic             timeout_hit;
  logic             phase_init;

`ifdef SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == S_ARM) begin
      tmo_cnt_d = '0;
    end else if (state_q == S_RUN && tmo_cnt_q != TMO_LAST) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  // RUN lasts exactly TIMEOUT cycles when no end pulse arrives.
  assign timeout_hit = (state_q == S_RUN) && (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge clk_40_m) begin
    if (!rst) tmo_cnt_q <= '0;
    else      tmo_cnt_q <= tmo_cnt_d;
  end
`else
  // No timeout counter in this build: the comparison is always false.
  assign timeout_hit = (TIMEOUT < 0);
`endif

  assign phase_init = (mode_q == MODE_TX) ? PH_TX : PH_RX;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    phase_d    = phase_q;
    last_bus_d = last_bus_q;
    bus_sel_d  = bus_sel_q;
    gap_cnt_d  = gap_cnt_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    err_bus_d  = err_bus_q;
    trim_d     = trim_q;
    end_hit    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_WAIT_SIGNON;
          mode_d     = mode;
          phase_d    = (mode == MODE_TX) ? PH_TX : PH_RX;
          last_bus_d = (n_buses > MAX_BUS) ? MAX_BUS : n_buses;
          bus_sel_d  = '0;
          pass_cnt_d = '0;
          fail_cnt_d = '0;
          err_bus_d  = '0;
          trim_d     = trim_en;
        end
      end
      S_WAIT_SIGNON: if (sign_on) state_d = S_ARM;
      S_ARM:         state_d = S_RUN;
      S_RUN: begin
        if (mode_q == MODE_ADV)     end_hit = test_advanced_end;
        else if (phase_q == PH_TX)  end_hit = test_tx_end;
        else                        end_hit = test_rx_end;
        if (end_hit) begin
          if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + CNT_W'(1);
          state_d = S_ENDWAIT;
        end else if (timeout_hit) begin
          if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_W'(1);
          err_bus_d = bus_sel_q;
          state_d   = S_ENDWAIT;
        end
      end
      S_ENDWAIT: begin
        gap_cnt_d = '0;
        state_d   = (GAP_CYCLES == 0) ? S_NEXT : S_GAP;
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = S_NEXT;
        else                       gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      S_NEXT: begin
        if (mode_q == MODE_RXTX && phase_q == PH_RX) begin
          phase_d = PH_TX;
          state_d = S_ARM;
        end else if (bus_sel_q < last_bus_q) begin
          bus_sel_d = bus_sel_q + BUS_W'(1);
          phase_d   = phase_init;
          state_d   = S_ARM;
        end else if (loop_en) begin
          bus_sel_d = '0;
          phase_d   = phase_init;
          state_d   = S_ARM;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (end_power_init) trim_d = 1'b0;

    // Outputs are registered from the next state so they line up with it.
    test_rx_d  = (state_d == S_RUN) && (mode_d != MODE_ADV) && (phase_d == PH_RX);
    test_tx_d  = (state_d == S_RUN) && (mode_d != MODE_ADV) && (phase_d == PH_TX);
    test_adv_d = (state_d == S_RUN) && (mode_d == MODE_ADV);
    endwait_d  = (state_d == S_ENDWAIT);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_FINISH);
  end

  always_ff @(posedge clk_40_m) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      phase_q    <= PH_RX;
      last_bus_q <= '0;
      bus_sel_q  <= '0;
      gap_cnt_q  <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      err_bus_q  <= '0;
      test_rx_q  <= 1'b0;
      test_tx_q  <= 1'b0;
      test_adv_q <= 1'b0;
      endwait_q  <= 1'b0;
      trim_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      phase_q    <= phase_d;
      last_bus_q <= last_bus_d;
      bus_sel_q  <= bus_sel_d;
      gap_cnt_q  <= gap_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      err_bus_q  <= err_bus_d;
      test_rx_q  <= test_rx_d;
      test_tx_q  <= test_tx_d;
      test_adv_q <= test_adv_d;
      endwait_q  <= endwait_d;
      trim_q     <= trim_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign test_rx       = test_rx_q;
  assign test_tx       = test_tx_q;
  assign test_advanced = test_adv_q;
  assign bus_sel       = bus_sel_q;
  assign endwait_all   = endwait_q;
  assign osc_auto_trim = trim_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass_cnt      = pass_cnt_q;
  assign fail_cnt      = fail_cnt_q;
  assign err_bus       = err_bus_q;

endmodule

// File: tb/tb_mopshub_test_sequencer.sv
`timescale 1ns/1ps
// Bench for mopshub_test_sequencer: randomized campaigns, an environment responder, and a scoreboard
// that checks each completed test (kind, bus, timing) against a list planned from the walk rules.
module tb_mopshub_test_sequencer;
  localparam int N_BUS      = 6;
  localparam int BUS_W      = 3;
  localparam int GAP_CYCLES = 6;
  localparam int TIMEOUT    = 40;
  localparam int CNT_W      = 3;
  localparam int MAXC       = (1 << CNT_W) - 1;
  localparam int EW         = 1 + 2 + BUS_W;

  logic             clk_40_m = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0, trim_en = 1'b0, loop_en = 1'b0;
  logic [1:0]       mode = '0;
  logic [BUS_W-1:0] n_buses = '0;
  logic             sign_on = 1'b0, end_power_init = 1'b0;
  logic             test_rx_end = 1'b0, test_tx_end = 1'b0, test_advanced_end = 1'b0;
  logic             test_rx, test_tx, test_advanced, endwait_all, osc_auto_trim, busy, done;
  logic [BUS_W-1:0] bus_sel, err_bus;
  logic [CNT_W-1:0] pass_cnt, fail_cnt;

  mopshub_test_sequencer #(
    .N_BUS(N_BUS), .BUS_W(BUS_W), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk_40_m(clk_40_m), .rst(rst), .start(start), .trim_en(trim_en), .mode(mode),
    .loop_en(loop_en), .n_buses(n_buses), .sign_on(sign_on), .end_power_init(end_power_init),
    .test_rx_end(test_rx_end), .test_tx_end(test_tx_end), .test_advanced_end(test_advanced_end),
    .test_rx(test_rx), .test_tx(test_tx), .test_advanced(test_advanced), .bus_sel(bus_sel),
    .endwait_all(endwait_all), .osc_auto_trim(osc_auto_trim), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err_bus(err_bus)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk_40_m = ~clk_40_m;
  int cyc = 0;
  always @(posedge clk_40_m) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 500000 ns");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];  // {timeout_expected, kind(0 RX,1 TX,2 ADV), bus}
  int n_tests = 0, n_fail = 0;
  int exp_pass, exp_fail, exp_err;
  int no_reply_bus = -1;
  int last_end_cyc = 0, signon_cyc = 0;
  bit pending_signon = 0;
  int done_count = 0, ew_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int x);
    return (x > MAXC) ? MAXC : x;
  endfunction

  // Reference model: the list of tests a campaign must perform, in order.
  task automatic push_test(input int kind, input int b);
    bit tmo;
    tmo = (b == no_reply_bus);
    exp_q.push_back({tmo, 2'(kind), BUS_W'(b)});
    if (tmo) begin exp_fail++; exp_err = b; end
    else exp_pass++;
  endtask

  task automatic plan(input int md, input int nb, input int loops);
    int last;
    last = (nb > N_BUS - 1) ? N_BUS - 1 : nb;
    exp_pass = 0; exp_fail = 0; exp_err = 0;
    for (int l = 0; l < loops; l++)
      for (int b = 0; b <= last; b++) begin
        if (md == 2) begin push_test(0, b); push_test(1, b); end
        else push_test((md == 3) ? 2 : md, b);
      end
  endtask

  // ---------------- environment responder ----------------
  initial begin : responder
    int left;
    bit active;
    active = 0; left = 0;
    forever begin
      @(posedge clk_40_m); #1;
      test_rx_end = 0; test_tx_end = 0; test_advanced_end = 0;
      if (!(test_rx || test_tx || test_advanced)) active = 0;
      else if (!active) begin
        active = 1;
        left = $urandom_range(1, 12);
      end else begin
        left--;
        if (left == 0 && int'(bus_sel) != no_reply_bus) begin
          test_rx_end = test_rx; test_tx_end = test_tx; test_advanced_end = test_advanced;
          last_end_cyc = cyc;
        end else if ($urandom_range(0, 5) == 0) begin
          // Wrong-kind end pulse: must not complete the running test.
          test_tx_end = test_rx; test_advanced_end = test_tx; test_rx_end = test_advanced;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic [2:0]       req_now, req_prev = '0;
  logic [1:0]       cur_kind = '0;
  logic [BUS_W-1:0] cur_bus = '0;
  int rise_cyc = 0, ew_cyc = 0;
  bit have_ew = 0;

  always @(negedge clk_40_m) begin
    if (!rst) begin
      have_ew = 0;
      req_prev = '0;
    end else begin
      req_now = {test_advanced, test_tx, test_rx};
      check("req_onehot", ($countones(req_now) <= 1), 1);
      if (req_now != 0 && req_prev == 0) begin
        rise_cyc = cyc;
        cur_kind = req_now[2] ? 2'd2 : (req_now[1] ? 2'd1 : 2'd0);
        cur_bus  = bus_sel;
        if (pending_signon) begin
          check("signon_to_req", cyc - signon_cyc, 2);
          pending_signon = 0;
        end else if (have_ew) begin
          check("endwait_to_next_req", cyc - ew_cyc, GAP_CYCLES + 3);
        end
      end
      if (endwait_all) begin
        logic [EW-1:0] e;
        check("req_low_in_endwait", req_now, 0);
        check("bus_stable", bus_sel, cur_bus);
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_test: kind %0d bus %0d, expected none", cur_kind, cur_bus);
        end else begin
          e = exp_q.pop_front();
          check("test_kind_bus", {cur_kind, cur_bus}, e[EW-2:0]);
          if (e[EW-1]) check("timeout_len", cyc - rise_cyc, TIMEOUT);
          else         check("end_to_endwait", cyc - last_end_cyc, 1);
        end
        ew_cyc = cyc;
        have_ew = 1;
        ew_count++;
      end
      if (done) begin
        done_count++;
        have_ew = 0;
      end
      req_prev = req_now;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_40_m); #1;
  endtask

  task automatic start_campaign(input int md, input int nb, input bit trim, input bit lp);
    mode = 2'(md); n_buses = BUS_W'(nb); trim_en = trim; loop_en = lp; start = 1;
    tick();
    check("busy_after_start", busy, 1);
    check("trim_after_start", osc_auto_trim, trim);
    check("counters_cleared", {pass_cnt, fail_cnt, err_bus, bus_sel}, 0);
    repeat ($urandom_range(0, 2)) tick();
    start = 0;
  endtask

  task automatic send_signon();
    repeat ($urandom_range(0, 3)) tick();
    sign_on = 1; signon_cyc = cyc; pending_signon = 1;
    tick();
    sign_on = 0;
  endtask

  task automatic wait_done(input int budget);
    int n, d0;
    n = 0; d0 = done_count;
    while (done_count == d0 && n < budget) begin tick(); n++; end
    if (done_count == d0) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles, expected one", budget);
    end
  endtask

  task automatic finish_check();
    int d0;
    d0 = done_count;
    wait_done(3000);
    check("done_once", done_count - d0, 1);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    check("pass_cnt", pass_cnt, sat(exp_pass));
    check("fail_cnt", fail_cnt, sat(exp_fail));
    check("err_bus", err_bus, exp_err);
    check("exp_q_drained", exp_q.size(), 0);
  endtask

  task automatic campaign(input int md, input int nb);
    plan(md, nb, 1);
    start_campaign(md, nb, 0, 0);
    send_signon();
    finish_check();
    repeat (3) tick();
  endtask

  // ---------------- main stimulus ----------------
  initial begin : stim
    int n, ew0, d0;
    rst = 0;
    repeat (3) tick();
    check("outputs_in_reset", {test_rx, test_tx, test_advanced, bus_sel, endwait_all,
          osc_auto_trim, busy, done, pass_cnt, fail_cnt, err_bus}, 0);
    rst = 1;
    tick();

    // sign_on before start is ignored; trim requested and cleared by end_power_init
    sign_on = 1; tick(); sign_on = 0; tick();
    plan(0, 0, 1);
    start_campaign(0, 0, 1, 0);
    repeat (5) tick();
    check("no_req_before_signon", {test_rx, test_tx, test_advanced}, 0);
    check("busy_waiting_signon", busy, 1);
    end_power_init = 1; tick();
    end_power_init = 0;
    check("trim_cleared", osc_auto_trim, 0);
    send_signon();
    finish_check();

    campaign(1, 3);
    campaign(2, 1);
    campaign(3, 2);
    campaign(2, 7);   // n_buses clamped to N_BUS-1, pass_cnt saturates
    campaign(0, 7);
`ifdef SEQ_TIMEOUT_EN
    no_reply_bus = 2;
    campaign(1, 3);
    no_reply_bus = -1;
`endif
    for (int i = 0; i < 3; i++) campaign($urandom_range(0, 3), $urandom_range(0, 7));

    // loop mode: 0,1,0,1 then drop loop_en before the last NEXT
    plan(1, 1, 2);
    d0 = done_count;
    start_campaign(1, 1, 0, 1);
    send_signon();
    n = 0;
    while (exp_q.size() > 1 && n < 2000) begin tick(); n++; end
    check("loop_progress", exp_q.size(), 1);
    check("no_done_while_looping", done_count - d0, 0);
    loop_en = 0;
    finish_check();
    repeat (3) tick();

    // reset in the middle of a RUN on bus 5, then restart from bus 0
    plan(1, 7, 1);
    start_campaign(1, 7, 0, 0);
    send_signon();
    n = 0;
    while (!(test_tx && bus_sel == 3'd5) && n < 2000) begin tick(); n++; end
    check("reached_bus5", {test_tx, bus_sel}, {1'b1, 3'd5});
    ew0 = ew_count;
    rst = 0;
    tick();
    check("outputs_after_mid_reset", {test_rx, test_tx, test_advanced, bus_sel, endwait_all,
          osc_auto_trim, busy, done, pass_cnt, fail_cnt, err_bus}, 0);
    check("tests_before_reset", ew0, ew_count);
    rst = 1;
    exp_q.delete();
    pending_signon = 0;
    tick();
    campaign(0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
